// File: rtl/color_detector.sv
// color_detector
// Watches the pixel stream read back from the frame buffer and counts strongly
// red and strongly blue pixels inside the active image. At each frame end it
// publishes the two totals and a colour decision. RESULT[2] is set when the
// colour decided for this frame matches the colour decided for the last one.
module color_detector #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144,
  parameter int MIN_COUNT     = 2000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  PIXEL_IN,
  input  logic [9:0]  VGA_PIXEL_X,
  input  logic [9:0]  VGA_PIXEL_Y,
  input  logic        VGA_VSYNC_NEG,
  output logic [8:0]  RESULT,
  output logic [14:0] RED_COUNT,
  output logic [14:0] BLUE_COUNT,
  output logic        FRAME_DONE
);

  // Sized copies of the parameters. Comparisons then happen at a known width.
  localparam logic [10:0] WIDTH_LIM  = 11'(SCREEN_WIDTH);
  localparam logic [10:0] HEIGHT_LIM = 11'(SCREEN_HEIGHT);
  localparam logic [14:0] MIN_CNT    = 15'(MIN_COUNT);
  localparam logic [14:0] ACC_MAX    = 15'h7FFF;

  localparam logic [1:0] COLOR_NONE = 2'b00;
  localparam logic [1:0] COLOR_RED  = 2'b01;
  localparam logic [1:0] COLOR_BLUE = 2'b10;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    ACCUM,
    DECIDE
  } state_t;

  state_t      state;

  logic [9:0]  x_d;
  logic [9:0]  y_d;

  logic        vsync_q;
  logic        vsync_prev;
  logic        frame_end;

  logic [2:0]  pix_r;
  logic [2:0]  pix_g;
  logic [1:0]  pix_b;
  logic        in_area;
  logic        is_red;
  logic        is_blue;

  logic [14:0] red_acc;
  logic [14:0] blue_acc;

  logic [1:0]  new_color;
  logic        new_stable;

  logic [1:0]  color_q;
  logic        stable_q;
  logic [1:0]  prev_color;

  // The RAM returns the pixel one cycle after its address, so delay the scan coordinates by one cycle to line them up.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      x_d <= '0;
      y_d <= '0;
    end else begin
      x_d <= VGA_PIXEL_X;
      y_d <= VGA_PIXEL_Y;
    end
  end

  // Two-stage vsync sampling. The falling edge is seen one cycle after the first low sample, which places the decision on the second edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vsync_q    <= 1'b1;
      vsync_prev <= 1'b1;
    end else begin
      vsync_q    <= VGA_VSYNC_NEG;
      vsync_prev <= vsync_q;
    end
  end

  assign frame_end = vsync_prev & ~vsync_q;

  // Classify the pixel now on the bus, using its delayed coordinates. The red rule needs R >= 4 and the blue rule needs R <= 2, so no pixel matches both.
  always_comb begin
    pix_r   = PIXEL_IN[7:5];
    pix_g   = PIXEL_IN[4:2];
    pix_b   = PIXEL_IN[1:0];
    in_area = ({1'b0, x_d} < WIDTH_LIM) && ({1'b0, y_d} < HEIGHT_LIM);
    is_red  = in_area && (pix_r >= 3'd4) && (pix_g <= 3'd2) && (pix_b <= 2'd1);
    is_blue = in_area && (pix_b >= 2'd2) && (pix_r <= 3'd2) && (pix_g <= 3'd3);
  end

  // Decide the frame colour from the accumulators. A tie gives no colour, even when both counts are large.
  always_comb begin
    new_color = COLOR_NONE;
    if ((red_acc > blue_acc) && (red_acc >= MIN_CNT)) begin
      new_color = COLOR_RED;
    end else if ((blue_acc > red_acc) && (blue_acc >= MIN_CNT)) begin
      new_color = COLOR_BLUE;
    end
    new_stable = (new_color != COLOR_NONE) && (new_color == prev_color);
  end

  // Frame FSM. It owns the accumulators and all registered outputs. Nothing is published until one full frame has been seen.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= WAIT_FRAME;
      red_acc    <= '0;
      blue_acc   <= '0;
      RED_COUNT  <= '0;
      BLUE_COUNT <= '0;
      color_q    <= COLOR_NONE;
      stable_q   <= 1'b0;
      prev_color <= COLOR_NONE;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      case (state)
        WAIT_FRAME: begin
          red_acc  <= '0;
          blue_acc <= '0;
          if (frame_end) begin
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (is_red && (red_acc != ACC_MAX)) begin
            red_acc <= red_acc + 15'd1;
          end
          if (is_blue && (blue_acc != ACC_MAX)) begin
            blue_acc <= blue_acc + 15'd1;
          end
          if (frame_end) begin
            state <= DECIDE;
          end
        end
        DECIDE: begin
          RED_COUNT  <= red_acc;
          BLUE_COUNT <= blue_acc;
          color_q    <= new_color;
          stable_q   <= new_stable;
          prev_color <= new_color;
          FRAME_DONE <= 1'b1;
          red_acc    <= '0;
          blue_acc   <= '0;
          state      <= ACCUM;
        end
        default: begin
          state    <= WAIT_FRAME;
          red_acc  <= '0;
          blue_acc <= '0;
        end
      endcase
    end
  end

  assign RESULT = {6'b000000, stable_q, color_q};

endmodule

// File: tb/tb_color_detector.sv
// tb_color_detector
// Directed frames with hand-computed totals. The stimulus pushes the expected
// decision into a queue. A monitor pops and compares each time FRAME_DONE pulses.
module tb_color_detector;

  logic        CLK;
  logic        RESET;
  logic [7:0]  PIXEL_IN;
  logic [9:0]  VGA_PIXEL_X;
  logic [9:0]  VGA_PIXEL_Y;
  logic        VGA_VSYNC_NEG;
  logic [8:0]  RESULT;
  logic [14:0] RED_COUNT;
  logic [14:0] BLUE_COUNT;
  logic        FRAME_DONE;

  typedef struct packed {
    logic [8:0]  result;
    logic [14:0] red;
    logic [14:0] blue;
  } exp_t;

  exp_t exp_q[$];

  int n_compared      = 0;
  int n_mismatched    = 0;
  int n_pushed        = 0;
  int n_frame_done    = 0;
  int frame_pos       = 0;
  logic [7:0] pend_pix = 8'h00;

  color_detector #(
    .SCREEN_WIDTH (176),
    .SCREEN_HEIGHT(144),
    .MIN_COUNT    (2000)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PIXEL_IN     (PIXEL_IN),
    .VGA_PIXEL_X  (VGA_PIXEL_X),
    .VGA_PIXEL_Y  (VGA_PIXEL_Y),
    .VGA_VSYNC_NEG(VGA_VSYNC_NEG),
    .RESULT       (RESULT),
    .RED_COUNT    (RED_COUNT),
    .BLUE_COUNT   (BLUE_COUNT),
    .FRAME_DONE   (FRAME_DONE)
  );

  // 100 MHz clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One scan cycle. This drives the address for this cycle. It also drives the pixel for the previous address, which models the one-cycle RAM latency.
  task automatic applyStimulus(input int x, input int y, input logic vs, input logic [7:0] pix);
    @(negedge CLK);
    VGA_PIXEL_X   = 10'(x);
    VGA_PIXEL_Y   = 10'(y);
    VGA_VSYNC_NEG = vs;
    PIXEL_IN      = pend_pix;
    pend_pix      = pix;
  endtask

  task automatic send_pixels(input int n, input logic [7:0] pix);
    for (int i = 0; i < n; i++) begin
      applyStimulus(frame_pos % 176, frame_pos / 176, 1'b1, pix);
      frame_pos++;
    end
  endtask

  task automatic frame_end(input int low_cycles);
    for (int i = 0; i < 2; i++) applyStimulus(700, 500, 1'b1, 8'hE0);
    for (int i = 0; i < low_cycles; i++) applyStimulus(700, 500, 1'b0, 8'hE0);
    for (int i = 0; i < 3; i++) applyStimulus(700, 500, 1'b1, 8'hE0);
    frame_pos = 0;
  endtask

  task automatic expect_decision(input logic [8:0] res, input logic [14:0] red, input logic [14:0] blue);
    exp_q.push_back({res, red, blue});
    n_pushed++;
  endtask

  task automatic wait_drained();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge CLK);
    checkOutput("decision_seen", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor. Every FRAME_DONE pulse must match the oldest expected decision. A pulse with nothing queued is itself a failure.
  always @(negedge CLK) begin
    if (!RESET && FRAME_DONE) begin
      exp_t e;
      n_frame_done++;
      if (exp_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_frame_done: got pulse expected none");
      end else begin
        e = exp_q.pop_front();
        checkOutput("result", 32'(RESULT), 32'(e.result));
        checkOutput("red_count", 32'(RED_COUNT), 32'(e.red));
        checkOutput("blue_count", 32'(BLUE_COUNT), 32'(e.blue));
      end
    end
  end

  initial begin
    RESET         = 1'b1;
    PIXEL_IN      = 8'h00;
    VGA_PIXEL_X   = '0;
    VGA_PIXEL_Y   = '0;
    VGA_VSYNC_NEG = 1'b1;
    #12;
    checkOutput("reset_result", 32'(RESULT), 0);
    checkOutput("reset_red", 32'(RED_COUNT), 0);
    checkOutput("reset_blue", 32'(BLUE_COUNT), 0);
    checkOutput("reset_frame_done", 32'(FRAME_DONE), 0);
    @(negedge CLK);
    RESET = 1'b0;

    // Partial first frame. Its frame-end edge only arms the FSM.
    $display("[TB] partial first frame");
    send_pixels(500, 8'hE0);
    frame_end(2);
    repeat (10) applyStimulus(700, 500, 1'b1, 8'h00);

    $display("[TB] full red frames");
    send_pixels(25344, 8'hE0);
    expect_decision(9'h001, 15'd25344, 15'd0);
    frame_end(2);
    wait_drained();
    send_pixels(25344, 8'hE0);
    expect_decision(9'h005, 15'd25344, 15'd0);
    frame_end(2);
    wait_drained();

    $display("[TB] blue frame");
    send_pixels(3000, 8'h03);
    send_pixels(200, 8'hFF);
    expect_decision(9'h002, 15'd0, 15'd3000);
    frame_end(2);
    wait_drained();

    $display("[TB] tie frame");
    send_pixels(2500, 8'hE0);
    send_pixels(2500, 8'h03);
    expect_decision(9'h000, 15'd2500, 15'd2500);
    frame_end(2);
    wait_drained();

    $display("[TB] below minimum");
    send_pixels(1999, 8'hE0);
    expect_decision(9'h000, 15'd1999, 15'd0);
    frame_end(2);
    wait_drained();

    // Red pixels outside the active area must be ignored. Vsync stays low for two lines.
    $display("[TB] out of range and long vsync");
    send_pixels(2100, 8'hE0);
    for (int x = 176; x < 640; x++) applyStimulus(x, 0, 1'b1, 8'hE0);
    for (int y = 144; y < 480; y++) applyStimulus(0, y, 1'b1, 8'hE0);
    applyStimulus(639, 479, 1'b1, 8'hE0);
    expect_decision(9'h001, 15'd2100, 15'd0);
    frame_end(1600);
    wait_drained();

    // Outputs hold between decisions.
    send_pixels(300, 8'h03);
    checkOutput("hold_result", 32'(RESULT), 32'h001);
    checkOutput("hold_red", 32'(RED_COUNT), 2100);
    checkOutput("hold_blue", 32'(BLUE_COUNT), 0);

    $display("[TB] reset mid-frame");
    send_pixels(2200, 8'hE0);
    #2;
    RESET = 1'b1;
    #1;
    checkOutput("midreset_result", 32'(RESULT), 0);
    checkOutput("midreset_red", 32'(RED_COUNT), 0);
    checkOutput("midreset_blue", 32'(BLUE_COUNT), 0);
    checkOutput("midreset_frame_done", 32'(FRAME_DONE), 0);
    #1;
    RESET = 1'b0;
    send_pixels(500, 8'hE0);
    frame_end(2);
    repeat (10) applyStimulus(700, 500, 1'b1, 8'h00);

    send_pixels(2050, 8'hE0);
    expect_decision(9'h001, 15'd2050, 15'd0);
    frame_end(2);
    wait_drained();
    send_pixels(2050, 8'hE0);
    expect_decision(9'h005, 15'd2050, 15'd0);
    frame_end(2);
    wait_drained();

    repeat (10) applyStimulus(700, 500, 1'b1, 8'h00);
    checkOutput("frame_done_pulses", n_frame_done, n_pushed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
